// File: rtl/timer_sequencer.sv
// Drives an Avalon-MM interval timer through a run of num_ticks timeouts (0 = until abort).
// Define TIMER_SEQ_SNAPSHOT_EN to read the timer snapshot back into snap_value after every tick.
module timer_sequencer #(
    parameter int CLK_PERIOD_GUARD = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] period,
    input  logic [15:0] num_ticks,
    input  logic        continuous,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        done,
    output logic        aborted
`ifdef TIMER_SEQ_SNAPSHOT_EN
    ,
    output logic [31:0] snap_value
`endif
);

    typedef enum logic [3:0] {
        IDLE, WR_STOP, WR_PL, WR_PH, GUARD, WR_CTRL, WAIT_IRQ, CLR_STAT, FIN_STOP, DONE
`ifdef TIMER_SEQ_SNAPSHOT_EN
        , SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP
`endif
    } state_t;

    typedef struct packed {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [15:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs: 1'b0, wn: 1'b1, addr: 3'd0, data: 16'h0000};
    localparam logic [1:0] GUARD_LAST = 2'((CLK_PERIOD_GUARD > 0) ? CLK_PERIOD_GUARD - 1 : 0);

    state_t      state, nxt, after_tick;
    bus_t        bus_q;
    logic [31:0] period_q;
    logic [15:0] num_q;
    logic        cont_q;
    logic [1:0]  guard_cnt;
    logic        abort_ok;

    assign tmr_chipselect = bus_q.cs;
    assign tmr_write_n    = bus_q.wn;
    assign tmr_address    = bus_q.addr;
    assign tmr_writedata  = bus_q.data;

    assign abort_ok = abort && (state != IDLE) && (state != FIN_STOP) && (state != DONE);

    // Bus cycle to present while sitting in state s; registered one edge ahead.
    function automatic bus_t bus_for(input state_t s, input logic [31:0] p, input logic c);
        bus_t b;
        b = '{cs: 1'b1, wn: 1'b0, addr: 3'd0, data: 16'h0000};
        case (s)
            WR_STOP:  begin b.addr = 3'd1; b.data = 16'h0008; end
            WR_PL:    begin b.addr = 3'd2; b.data = p[15:0]; end
            WR_PH:    begin b.addr = 3'd3; b.data = p[31:16]; end
            WR_CTRL:  begin b.addr = 3'd1; b.data = c ? 16'h0007 : 16'h0005; end
            CLR_STAT: begin b.addr = 3'd0; b.data = 16'h0000; end
            FIN_STOP: begin b.addr = 3'd1; b.data = 16'h0008; end
`ifdef TIMER_SEQ_SNAPSHOT_EN
            SNAP_WR:  begin b.addr = 3'd4; b.data = 16'h0000; end
            SNAP_RDL: begin b.wn = 1'b1; b.addr = 3'd4; end
            SNAP_RDH: begin b.wn = 1'b1; b.addr = 3'd5; end
`endif
            default:  b = BUS_IDLE;
        endcase
        return b;
    endfunction

    always_comb begin
        // tick_count already holds the post-increment value while in CLR_STAT
        if ((num_q != 16'd0) && (tick_count == num_q)) after_tick = FIN_STOP;
        else if (cont_q)                                 after_tick = WAIT_IRQ;
        else                                             after_tick = WR_CTRL;

        nxt = state;
        case (state)
            IDLE:     if (start) nxt = WR_STOP;
            WR_STOP:  nxt = WR_PL;
            WR_PL:    nxt = WR_PH;
            WR_PH:    nxt = (CLK_PERIOD_GUARD > 0) ? GUARD : WR_CTRL;
            GUARD:    if (guard_cnt == 2'd0) nxt = WR_CTRL;
            WR_CTRL:  nxt = WAIT_IRQ;
            WAIT_IRQ: if (tmr_irq) nxt = CLR_STAT;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            CLR_STAT: nxt = SNAP_WR;
            SNAP_WR:  nxt = SNAP_RDL;
            SNAP_RDL: nxt = SNAP_RDH;
            SNAP_RDH: nxt = SNAP_CAP;
            SNAP_CAP: nxt = after_tick;
`else
            CLR_STAT: nxt = after_tick;
`endif
            FIN_STOP: nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        if (abort_ok) nxt = FIN_STOP;
    end

`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [15:0] snap_lo;
`else
    logic unused_readdata;
    assign unused_readdata = ^tmr_readdata;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bus_q      <= BUS_IDLE;
            busy       <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
            tick_count <= 16'd0;
            aborted    <= 1'b0;
            period_q   <= 32'd0;
            num_q      <= 16'd0;
            cont_q     <= 1'b0;
            guard_cnt  <= 2'd0;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            snap_lo    <= 16'd0;
            snap_value <= 32'd0;
`endif
        end else begin
            state <= nxt;
            bus_q <= bus_for(nxt, period_q, cont_q);
            busy  <= (nxt != IDLE);
            tick  <= (nxt == CLR_STAT);
            done  <= (nxt == DONE);

            if (state == IDLE && start) begin
                period_q   <= period;
                num_q      <= num_ticks;
                cont_q     <= continuous;
                tick_count <= 16'd0;
                aborted    <= 1'b0;
            end
            if (abort_ok) aborted <= 1'b1;
            if (nxt == CLR_STAT) tick_count <= tick_count + 16'd1;

            if (nxt == GUARD && state != GUARD) guard_cnt <= GUARD_LAST;
            else if (state == GUARD)            guard_cnt <= guard_cnt - 2'd1;
`ifdef TIMER_SEQ_SNAPSHOT_EN
            // read latency is one cycle: addr4 data arrives in SNAP_RDH, addr5 data in SNAP_CAP
            if (state == SNAP_RDH) snap_lo    <= tmr_readdata;
            if (state == SNAP_CAP) snap_value <= {tmr_readdata, snap_lo};
`endif
        end
    end

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: write scoreboard, behavioural timer, vector table.
module tb_timer_sequencer;
    localparam int GUARD   = 1;
    localparam int IRQ_DLY = 3;

    logic        clk = 1'b0;
    logic        reset, start, abort, continuous;
    logic [31:0] period;
    logic [15:0] num_ticks;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata, tmr_readdata;
    logic        tmr_irq;
    logic        busy, tick, done, aborted;
    logic [15:0] tick_count;
`ifdef TIMER_SEQ_SNAPSHOT_EN
    logic [31:0] snap_value;
`endif

    timer_sequencer #(.CLK_PERIOD_GUARD(GUARD)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .period(period), .num_ticks(num_ticks), .continuous(continuous),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
        .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
        .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
        .busy(busy), .tick(tick), .tick_count(tick_count), .done(done), .aborted(aborted)
`ifdef TIMER_SEQ_SNAPSHOT_EN
        , .snap_value(snap_value)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [2:0] addr; logic [15:0] data; } wr_t;
    typedef struct {
        logic [31:0] period;
        logic [15:0] num;
        logic        cont;
        int          abort_at;
        logic [15:0] exp_cnt;
        logic        exp_abort;
    } vec_t;

    wr_t  exp_q[$];
    int   checks = 0, errors = 0, cyc = 0, ph_cyc = 0;
    bit   ph_valid = 0;
    // behavioural timer
    bit   running = 0, tcont = 0, irq_manual = 0;
    int   tcnt = 0;
    logic model_irq = 1'b0, man_irq = 1'b0;
    logic [15:0] rd_pend = 16'h0;

    assign tmr_irq = irq_manual ? man_irq : model_irq;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        running = 0; model_irq = 1'b0; tcnt = 0; ph_valid = 0;
    endtask

    task automatic push(input logic [2:0] a, input logic [15:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    // Expected write stream of one run that counts n ticks
    task automatic push_run(input logic [31:0] p, input logic c, input int n, input bit abort_last);
        push(3'd1, 16'h0008);
        push(3'd2, p[15:0]);
        push(3'd3, p[31:16]);
        for (int i = 1; i <= n; i++) begin
            if (i == 1 || !c) push(3'd1, c ? 16'h0007 : 16'h0005);
            push(3'd0, 16'h0000);
`ifdef TIMER_SEQ_SNAPSHOT_EN
            if (!(abort_last && i == n)) push(3'd4, 16'h0000);
`endif
        end
        push(3'd1, 16'h0008);
    endtask

    // One clock: sample outputs, compare writes against the scoreboard, advance the timer model
    task automatic step();
        wr_t w;
        @(posedge clk); #1;
        cyc++;
        if (tmr_chipselect && !tmr_write_n) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, none expected", tmr_address, tmr_writedata);
            end else begin
                w = exp_q.pop_front();
                check("write", {13'd0, tmr_address, tmr_writedata}, {13'd0, w.addr, w.data});
            end
            if (tmr_address == 3'd3) begin ph_cyc = cyc; ph_valid = 1; end
            if (tmr_address == 3'd1 && tmr_writedata[2] && ph_valid) begin
                check("guard_gap", cyc - ph_cyc, GUARD + 1);
                ph_valid = 0;
            end
            if (tmr_address == 3'd1) begin
                if (tmr_writedata[3]) running = 0;
                if (tmr_writedata[2]) begin running = 1; tcont = tmr_writedata[1]; tcnt = IRQ_DLY; end
            end
            if (tmr_address == 3'd0) begin
                model_irq = 1'b0;
                if (running && tcont) tcnt = IRQ_DLY;
            end
        end else if (running && !model_irq) begin
            if (tcnt == 0) begin model_irq = 1'b1; if (!tcont) running = 0; end
            else tcnt--;
        end
        tmr_readdata = rd_pend;
        rd_pend = (tmr_chipselect && tmr_write_n && tmr_address == 3'd4) ? 16'h1234 : 16'h0000;
    endtask

    task automatic wait_done(input string nm, input int abort_at, input logic [15:0] exp_cnt, input logic exp_ab);
        int  ticks_seen = 0;
        bit  got = 0;
        for (int n = 0; n < 2000 && !got; n++) begin
            step();
            start = 1'b0; abort = 1'b0;
            if (tick) begin
                ticks_seen++;
                if (abort_at != 0 && tick_count == 16'(abort_at)) abort = 1'b1;
            end
            if (done) got = 1;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s.timeout: got no done, required done within 2000 cycles", nm);
        end else begin
            check({nm, ".tick_count"}, tick_count, exp_cnt);
            check({nm, ".aborted"}, aborted, exp_ab);
            check({nm, ".tick_pulses"}, ticks_seen, exp_cnt);
            check({nm, ".writes_left"}, exp_q.size(), 0);
            step();
            check({nm, ".done_pulse"}, done, 1'b0);
            check({nm, ".busy_after"}, busy, 1'b0);
        end
        exp_q.delete();
        model_clear();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{32'h0001_86A0, 16'd2, 1'b1, 0, 16'd2, 1'b0};
        vecs[1] = '{32'h0000_0010, 16'd3, 1'b0, 0, 16'd3, 1'b0};
        vecs[2] = '{32'h1234_5678, 16'd0, 1'b1, 5, 16'd5, 1'b1};
        vecs[3] = '{32'h0000_0000, 16'd1, 1'b0, 0, 16'd1, 1'b0};
        vecs[4] = '{32'hFFFF_0001, 16'd2, 1'b0, 0, 16'd2, 1'b0};

        reset = 1'b1; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        period = 32'd0; num_ticks = 16'd0; tmr_readdata = 16'h0;
        repeat (2) step();
        check("rst.busy", busy, 1'b0);
        check("rst.cs", tmr_chipselect, 1'b0);
        check("rst.write_n", tmr_write_n, 1'b1);
        check("rst.addr", tmr_address, 3'd0);
        check("rst.wdata", tmr_writedata, 16'h0);
        check("rst.tick_count", tick_count, 16'h0);
        check("rst.flags", {tick, done, aborted}, 3'b000);

        // abort while idle does nothing
        reset = 1'b0; abort = 1'b1;
        step(); abort = 1'b0;
        step();
        check("idle_abort.busy", busy, 1'b0);
        check("idle_abort.aborted", aborted, 1'b0);

        for (int i = 0; i < 5; i++) begin
            push_run(vecs[i].period, vecs[i].cont, int'(vecs[i].exp_cnt), vecs[i].exp_abort);
            period = vecs[i].period; num_ticks = vecs[i].num; continuous = vecs[i].cont;
            start = 1'b1;
            step(); start = 1'b0;
            check($sformatf("vec%0d.busy", i), busy, 1'b1);
            wait_done($sformatf("vec%0d", i), vecs[i].abort_at, vecs[i].exp_cnt, vecs[i].exp_abort);
`ifdef TIMER_SEQ_SNAPSHOT_EN
            if (i == 0) check("snap_value", snap_value, 32'h0000_1234);
`endif
        end

        // abort and irq in the same WAIT_IRQ cycle after one tick
        irq_manual = 1; man_irq = 1'b0;
        push(3'd1, 16'h0008); push(3'd2, 16'h0100); push(3'd3, 16'h0000);
        push(3'd1, 16'h0007); push(3'd0, 16'h0000);
`ifdef TIMER_SEQ_SNAPSHOT_EN
        push(3'd4, 16'h0000);
`endif
        push(3'd1, 16'h0008);
        period = 32'h100; num_ticks = 16'd0; continuous = 1'b1; start = 1'b1;
        step(); start = 1'b0;
        repeat (8) step();
        man_irq = 1'b1;
        step(); man_irq = 1'b0;
        check("race.first_tick", {tick, tick_count}, {1'b1, 16'd1});
        repeat (8) step();
        man_irq = 1'b1; abort = 1'b1;
        step(); man_irq = 1'b0; abort = 1'b0;
        check("race.no_tick", tick, 1'b0);
        step();
        check("race.done", done, 1'b1);
        check("race.tick_count", tick_count, 16'd1);
        check("race.aborted", aborted, 1'b1);
        check("race.writes_left", exp_q.size(), 0);
        exp_q.delete(); irq_manual = 0; model_clear();
        step();

        // reset in WR_PH: no stop write, straight to idle
        push(3'd1, 16'h0008); push(3'd2, 16'h5555); push(3'd3, 16'hAAAA);
        period = 32'hAAAA_5555; num_ticks = 16'd1; continuous = 1'b0; start = 1'b1;
        step(); start = 1'b0;
        step(); step();
        check("rst_ph.in_ph", tmr_address, 3'd3);
        reset = 1'b1;
        step(); reset = 1'b0;
        check("rst_ph.busy", busy, 1'b0);
        check("rst_ph.cs", tmr_chipselect, 1'b0);
        check("rst_ph.bus", {tmr_write_n, tmr_address, tmr_writedata}, {1'b1, 3'd0, 16'h0});
        model_clear();
        repeat (4) step();
        check("rst_ph.writes_left", exp_q.size(), 0);

        // start while busy is ignored; original period/num_ticks/mode stay in force
        push_run(32'hAAAA_5555, 1'b0, 1, 1'b0);
        start = 1'b1;
        step();
        period = 32'h0BAD_F00D; num_ticks = 16'd5; continuous = 1'b1; start = 1'b1;
        wait_done("busy_start", 0, 16'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
